// File: rtl/bubble_status_tracker.sv
// rtl/bubble_status_tracker.sv - front-panel status conditioner for the bubble emulator
//
// Purpose: turns raw emulator status into stable, human-visible LED/FND drive signals.
//   - stretches access-type activity so short accesses stay visible
//   - latches the current page on a strobe, rejecting out-of-range pages
//   - synchronises BUSY_IN into nWAIT with a guaranteed minimum low time
//
// Ports (top):
//   MCLK        in   1   system clock
//   nRESET      in   1   asynchronous active-low reset
//   ACCTYPE_IN  in   3   raw access type: [2] active, [1] read, [0] write qualifier
//   PAGE_IN     in   12  raw page number
//   PAGE_STB    in   1   one-cycle strobe, PAGE_IN valid
//   BUSY_IN     in   1   asynchronous loading/initialising flag, active high
//   nWAIT       out  1   0 = show waiting animation
//   ACCTYPE     out  3   stretched access type
//   CURRPAGE    out  12  latched page number

// Two-flop synchroniser for a single asynchronous level.
module bst_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule

// Minimum-period wait timer. Reset behaves like a busy pulse that has just
// ended, so nWAIT stays low for WAIT_MIN_CYCLES cycles after reset release.
module bst_wait_timer #(
    parameter int WAIT_MIN_CYCLES = 24_000_000,
    parameter int CNT_W           = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_busy_s,
    output logic o_nwait
);
    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(WAIT_MIN_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_nwait;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= WAIT_RELOAD;
            r_nwait <= 1'b0;
        end else if (i_busy_s) begin
            // Any busy cycle restarts the full minimum period.
            r_cnt   <= WAIT_RELOAD;
            r_nwait <= 1'b0;
        end else if (!w_cnt_zero) begin
            r_cnt   <= r_cnt - 1'b1;
            r_nwait <= 1'b0;
        end else begin
            r_nwait <= 1'b1;
        end
    end

    assign o_nwait = r_nwait;
endmodule

// Access-type stretcher: IDLE / ACTIVE / HOLD.
// The output is non-zero for exactly HOLD_CYCLES cycles after the last
// active input cycle; a new access always overrides a running hold.
module bst_access_stretch #(
    parameter int HOLD_CYCLES = 2_400_000,
    parameter int CNT_W       = 25
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_acctype,
    output logic [2:0] o_acctype
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACTIVE = 2'b01;
    localparam logic [1:0] ST_HOLD   = 2'b10;

    localparam int               HOLD_M1     = (HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_M1);
    localparam logic             HOLD_EN     = (HOLD_CYCLES > 0);

    logic [1:0]       r_state;
    logic [2:0]       r_acctype;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_active;

    assign w_active = i_acctype[2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_acctype  <= 3'b000;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_active) begin
                        r_state   <= ST_ACTIVE;
                        r_acctype <= i_acctype;
                    end else begin
                        r_acctype <= 3'b000;
                    end
                end
                ST_ACTIVE: begin
                    if (w_active) begin
                        r_acctype <= i_acctype;
                    end else if (HOLD_EN) begin
                        // Last active value is kept while the hold runs.
                        r_state    <= ST_HOLD;
                        r_hold_cnt <= HOLD_RELOAD;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_acctype <= 3'b000;
                    end
                end
                ST_HOLD: begin
                    if (w_active) begin
                        r_state   <= ST_ACTIVE;
                        r_acctype <= i_acctype;
                    end else if (r_hold_cnt == '0) begin
                        r_state   <= ST_IDLE;
                        r_acctype <= 3'b000;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_acctype <= 3'b000;
                end
            endcase
        end
    end

    assign o_acctype = r_acctype;
endmodule

// Page latch: accepts strobed pages below PAGE_LIMIT, ignores the rest.
module bst_page_latch #(
    parameter int PAGE_LIMIT = 2053
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_page,
    input  logic        i_stb,
    output logic [11:0] o_page
);
    // One extra bit so a limit of 4096 (accept everything) still compares correctly.
    localparam logic [12:0] LIMIT13 = 13'(PAGE_LIMIT);

    logic [11:0] r_page;
    logic        w_in_range;

    assign w_in_range = ({1'b0, i_page} < LIMIT13);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_page <= 12'h000;
        end else if (i_stb && w_in_range) begin
            r_page <= i_page;
        end
    end

    assign o_page = r_page;
endmodule

module bubble_status_tracker #(
    parameter int HOLD_CYCLES     = 2_400_000,
    parameter int WAIT_MIN_CYCLES = 24_000_000,
    parameter int PAGE_LIMIT      = 2053,
    parameter int CNT_W           = 25
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic [2:0]  ACCTYPE_IN,
    input  logic [11:0] PAGE_IN,
    input  logic        PAGE_STB,
    input  logic        BUSY_IN,
    output logic        nWAIT,
    output logic [2:0]  ACCTYPE,
    output logic [11:0] CURRPAGE
);
    logic w_busy_s;

    bst_sync2 u_busy_sync (
        .i_clk   (MCLK),
        .i_rst_n (nRESET),
        .i_async (BUSY_IN),
        .o_sync  (w_busy_s)
    );

    bst_wait_timer #(
        .WAIT_MIN_CYCLES (WAIT_MIN_CYCLES),
        .CNT_W           (CNT_W)
    ) u_wait (
        .i_clk    (MCLK),
        .i_rst_n  (nRESET),
        .i_busy_s (w_busy_s),
        .o_nwait  (nWAIT)
    );

    bst_access_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_access (
        .i_clk     (MCLK),
        .i_rst_n   (nRESET),
        .i_acctype (ACCTYPE_IN),
        .o_acctype (ACCTYPE)
    );

    bst_page_latch #(
        .PAGE_LIMIT (PAGE_LIMIT)
    ) u_page (
        .i_clk   (MCLK),
        .i_rst_n (nRESET),
        .i_page  (PAGE_IN),
        .i_stb   (PAGE_STB),
        .o_page  (CURRPAGE)
    );
endmodule

// File: tb/tb_bubble_status_tracker.sv
// tb/tb_bubble_status_tracker.sv - self-checking bench for bubble_status_tracker
module tb_bubble_status_tracker;
    localparam int HOLD  = 8;
    localparam int WMIN  = 16;
    localparam int LIMIT = 2053;

    logic        clk;
    logic        rst_n;
    logic [2:0]  acc_in;
    logic [11:0] page_in;
    logic        page_stb;
    logic        busy_in;
    logic        nwait;
    logic [2:0]  acc_out;
    logic [11:0] currpage;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: time-stamp based, in edges since reset release.
    int          edge_n;
    int          last_act_edge;
    logic [2:0]  last_act_val;
    int          last_busy_edge;
    logic        busy_h1;
    logic        busy_h2;
    logic [11:0] exp_page;
    logic [2:0]  exp_acc;
    logic        exp_nwait;

    bubble_status_tracker #(
        .HOLD_CYCLES     (HOLD),
        .WAIT_MIN_CYCLES (WMIN),
        .PAGE_LIMIT      (LIMIT),
        .CNT_W           (25)
    ) dut (
        .MCLK       (clk),
        .nRESET     (rst_n),
        .ACCTYPE_IN (acc_in),
        .PAGE_IN    (page_in),
        .PAGE_STB   (page_stb),
        .BUSY_IN    (busy_in),
        .nWAIT      (nwait),
        .ACCTYPE    (acc_out),
        .CURRPAGE   (currpage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset release counts as a busy episode that just ended.
    task automatic model_reset();
        edge_n         = 0;
        last_act_edge  = -1000;
        last_act_val   = 3'b000;
        last_busy_edge = 0;
        busy_h1        = 1'b0;
        busy_h2        = 1'b0;
        exp_page       = 12'h000;
        exp_acc        = 3'b000;
        exp_nwait      = 1'b0;
    endtask

    task automatic model_edge();
        logic busy_s_used;
        edge_n++;
        // BUSY_IN seen by the second sync flop two edges late.
        busy_s_used = busy_h2;
        busy_h2     = busy_h1;
        busy_h1     = busy_in;
        if (busy_s_used) last_busy_edge = edge_n;
        exp_nwait = ((edge_n - last_busy_edge) >= WMIN);
        if (acc_in[2]) begin
            last_act_edge = edge_n;
            last_act_val  = acc_in;
        end
        exp_acc = ((edge_n - last_act_edge) <= HOLD) ? last_act_val : 3'b000;
        if (page_stb && (int'(page_in) < LIMIT)) exp_page = page_in;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nWAIT"},    {11'd0, nwait},  {11'd0, exp_nwait});
        chk({tag, ".ACCTYPE"},  {9'd0, acc_out}, {9'd0, exp_acc});
        chk({tag, ".CURRPAGE"}, currpage,        exp_page);
    endtask

    // Inputs are applied just after a falling edge; outputs checked at the next falling edge.
    task automatic step(input string tag, input logic [2:0] a, input logic [11:0] p,
                        input logic s, input logic b);
        acc_in   = a;
        page_in  = p;
        page_stb = s;
        busy_in  = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic b);
        for (int i = 0; i < n; i++) step(tag, 3'b000, 12'h000, 1'b0, b);
    endtask

    initial begin
        rst_n    = 1'b0;
        acc_in   = 3'b000;
        page_in  = 12'h000;
        page_stb = 1'b0;
        busy_in  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: nWAIT low for exactly 16 cycles after release
        idle("t1_wait", 20, 1'b0);

        // 2: single-cycle access, stretched by 8 cycles
        step("t2_acc", 3'b101, 12'h000, 1'b0, 1'b0);
        idle("t2_hold", 12, 1'b0);

        // 3: gap shorter than hold, then new access overrides
        step("t3_acc", 3'b110, 12'h000, 1'b0, 1'b0);
        idle("t3_gap", 3, 1'b0);
        step("t3_new", 3'b101, 12'h000, 1'b0, 1'b0);
        idle("t3_tail", 11, 1'b0);

        // 4: page limit boundary
        step("t4_804", 3'b000, 12'h804, 1'b1, 1'b0);
        step("t4_805", 3'b000, 12'h805, 1'b1, 1'b0);
        step("t4_fff", 3'b000, 12'hFFF, 1'b1, 1'b0);
        step("t4_nostb", 3'b000, 12'h100, 1'b0, 1'b0);
        idle("t4_idle", 2, 1'b0);

        // 5: busy pulse, then a re-pulse mid-period
        idle("t5_busy", 3, 1'b1);
        idle("t5_low", 10, 1'b0);
        idle("t5_rebusy", 2, 1'b1);
        idle("t5_after", 24, 1'b0);

        // 6: asynchronous reset while holding, then fresh access
        step("t6_page", 3'b000, 12'h123, 1'b1, 1'b0);
        step("t6_acc", 3'b111, 12'h000, 1'b0, 1'b0);
        idle("t6_hold", 3, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_acc2", 3'b101, 12'h000, 1'b0, 1'b0);
        idle("t6_hold2", 12, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [11:0] p;
            logic        s;
            logic        b;
            a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            p = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(2048, 2058)) : 12'($urandom);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 29) == 0);
            step("rand", a, p, s, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
